intc_ctrl: RTL and testbench

Programmable interrupt controller for the device bus. Latches rising edges from up to NSRC device interrupt lines, applies a software mask, and drives a single IRQ to the bridge, which forwards it as HWInt[0]. It exposes a 4-word register window at 0x7F30–0x7F3F. The CPU claims one source at a time by reading VEC and releases it by writing EOI. Nesting is not supported.

---
 rtl/intc_pkg.sv | 33 +++
 rtl/intc_prio_enc.sv | 24 ++
 rtl/intc_ctrl.sv | 133 +++++++++++++
 tb/tb_intc_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// state encoding, VEC word layout and the default decode base.
package intc_pkg;

   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned IDX_W         = 3;
   localparam int unsigned VEC_VALID_BIT = 31;

   // Register offsets as seen on PrAddr[3:2]
   localparam logic [1:0] OFF_MASK = 2'd0;
   localparam logic [1:0] OFF_PEND = 2'd1;
   localparam logic [1:0] OFF_VEC  = 2'd2;
   localparam logic [1:0] OFF_EOI  = 2'd3;

   localparam logic [27:0] BASE_HI_DEF = 28'h00007F3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // VEC read word: valid flag in the top bit, source index in the low bits
   function automatic logic [DATA_W-1:0] vec_word(input logic valid, input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] w;
      w                = '0;
      w[VEC_VALID_BIT] = valid;
      w[IDX_W-1:0]     = idx;
      return w;
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder over the active (pending & masked) sources.
//   req   : active request vector
//   idx   : index of the lowest set bit (0 when nothing is set)
//   valid : any request set
module intc_prio_enc
   import intc_pkg::*;
#(
   parameter int unsigned NSRC = 6
) (
   input  logic [NSRC-1:0]  req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan high to low so the lowest set bit is the last one written
   always_comb begin
      idx   = '0;
      valid = |req;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/intc_ctrl.sv
// Programmable interrupt controller: edge-latches device interrupt lines,
// masks them, and raises a single IRQ until the CPU claims the winning
// source through VEC; EOI releases the claim. No nesting.
//   clk, reset : clock, asynchronous active-low reset
//   PrAddr     : bus address ([31:4] block decode, [3:2] register select)
//   PrWD       : bus write data
//   we, re     : bus write / read strobes (re is one pulse per CPU load)
//   PrRD       : combinational read data, 0 when the block is not hit
//   irq_src    : device interrupt lines, synchronous to clk
//   IRQ        : registered interrupt request, high exactly while in ASSERT
module intc_ctrl
   import intc_pkg::*;
#(
   parameter int unsigned NSRC    = 6,
   parameter logic [27:0] BASE_HI = BASE_HI_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] PrAddr,
   input  logic [DATA_W-1:0] PrWD,
   input  logic              we,
   input  logic              re,
   output logic [DATA_W-1:0] PrRD,
   input  logic [NSRC-1:0]   irq_src,
   output logic              IRQ
);

   logic              hit;
   logic [1:0]        off;
   logic              mask_wr, pend_wr, eoi_req, vec_rd;
   logic [NSRC-1:0]   mask, pend, prev;
   logic [NSRC-1:0]   active, rise, pend_clr;
   logic              armed;
   logic [IDX_W-1:0]  idx, insvc;
   logic              valid;
   logic              claim, eoi_wr;
   logic              irq_next;
   state_t            state, state_next;
   logic              unused;

   // Address decode and bus strobes
   assign hit     = (PrAddr[31:4] == BASE_HI);
   assign off     = PrAddr[3:2];
   assign mask_wr = hit && we && (off == OFF_MASK);
   assign pend_wr = hit && we && (off == OFF_PEND);
   assign eoi_req = hit && we && (off == OFF_EOI);
   assign vec_rd  = hit && re && (off == OFF_VEC);

   assign active = pend & mask;

   intc_prio_enc #(.NSRC(NSRC)) u_prio (
      .req   (active),
      .idx   (idx),
      .valid (valid)
   );

   // Only a VEC read in ASSERT claims; only an EOI in SERVICE releases
   assign claim  = (state == ASSERT) && vec_rd && valid;
   assign eoi_wr = (state == SERVICE) && eoi_req;

   // The first cycle after reset only primes prev, so a line already high is not an edge
   assign rise = irq_src & ~prev & {NSRC{armed}};

   assign pend_clr = (pend_wr ? PrWD[NSRC-1:0] : '0)
                   | (claim   ? (NSRC'(1) << idx) : '0);

   // Source-side state: mask, pending edges, edge history, in-service index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask  <= '0;
         pend  <= '0;
         prev  <= '0;
         armed <= 1'b0;
         insvc <= '0;
      end else begin
         prev  <= irq_src;
         armed <= 1'b1;
         if (mask_wr) mask <= PrWD[NSRC-1:0];
         // New edges win over a same-cycle clear
         pend <= (pend & ~pend_clr) | rise;
         if (claim)       insvc <= idx;
         else if (eoi_wr) insvc <= '0;
      end
   end

   // State register; IRQ registered from the next state so it tracks ASSERT exactly
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         IRQ   <= 1'b0;
      end else begin
         state <= state_next;
         IRQ   <= irq_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (valid) state_next = ASSERT;
         ASSERT: begin
            if (claim)       state_next = SERVICE;
            else if (!valid) state_next = IDLE;
         end
         SERVICE: if (eoi_wr) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      irq_next = 1'b0;
      if (state_next == ASSERT) irq_next = 1'b1;
   end

   // Read mux
   always_comb begin
      PrRD = '0;
      if (hit) begin
         case (off)
            OFF_MASK: PrRD = DATA_W'(mask);
            OFF_PEND: PrRD = DATA_W'(pend);
            OFF_VEC:  PrRD = vec_word(valid, idx);
            default:  PrRD = '0;
         endcase
      end
   end

   // Bits with no consumer in this block
   assign unused = ^{PrAddr[1:0], PrWD, insvc};

endmodule

// File: tb/tb_intc_ctrl.sv
// Self-checking bench for intc_ctrl: register reads are scored through an
// expected-value queue, IRQ timing is checked cycle by cycle.
module tb_intc_ctrl;

   localparam int unsigned NSRC = 6;
   localparam logic [27:0] BASE = 28'h00007F3;
   localparam logic [1:0]  O_MASK = 2'd0;
   localparam logic [1:0]  O_PEND = 2'd1;
   localparam logic [1:0]  O_VEC  = 2'd2;
   localparam logic [1:0]  O_EOI  = 2'd3;

   logic            clk = 1'b0;
   logic            reset;
   logic [31:0]     PrAddr;
   logic [31:0]     PrWD;
   logic            we;
   logic            re;
   logic [31:0]     PrRD;
   logic [NSRC-1:0] irq_src;
   logic            IRQ;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   intc_ctrl #(.NSRC(NSRC), .BASE_HI(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .PrAddr  (PrAddr),
      .PrWD    (PrWD),
      .we      (we),
      .re      (re),
      .PrRD    (PrRD),
      .irq_src (irq_src),
      .IRQ     (IRQ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs are driven and outputs sampled at the negedge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      while (exp_q.size() > 0) check(tag_q.pop_front(), PrRD, exp_q.pop_front());
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
      PrAddr = {BASE, off, 2'b00};
      PrWD   = data;
      we     = 1'b1;
      tick();
      we     = 1'b0;
      PrWD   = '0;
   endtask

   task automatic raw_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      PrAddr = addr;
      re     = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      #1;
      drain();
      tick();
      re     = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] off, input logic [31:0] exp, input string tag);
      raw_read({BASE, off, 2'b00}, exp, tag);
   endtask

   initial begin
      reset   = 1'b0;
      PrAddr  = '0;
      PrWD    = '0;
      we      = 1'b0;
      re      = 1'b0;
      irq_src = '0;
      repeat (3) @(negedge clk);
      check("irq_in_reset", 32'(IRQ), 32'h0);
      reset = 1'b1;
      tick();

      // Reset state
      bus_read(O_MASK, 32'h0, "rst_mask");
      bus_read(O_PEND, 32'h0, "rst_pend");
      bus_read(O_VEC,  32'h0, "rst_vec");
      bus_read(O_EOI,  32'h0, "rst_eoi");
      check("rst_irq", 32'(IRQ), 32'h0);

      // Single source: pend at t+1, IRQ at t+2, claim, EOI
      bus_write(O_MASK, 32'h01);
      irq_src = 6'h01;
      tick();
      irq_src = '0;
      check("s0_irq_t1", 32'(IRQ), 32'h0);
      bus_read(O_PEND, 32'h1, "s0_pend_t1");
      check("s0_irq_t2", 32'(IRQ), 32'h1);
      bus_read(O_VEC, 32'h8000_0000, "s0_claim");
      check("s0_irq_svc", 32'(IRQ), 32'h0);
      bus_read(O_PEND, 32'h0, "s0_pend_svc");
      bus_write(O_EOI, 32'hDEAD_BEEF);
      check("s0_irq_eoi", 32'(IRQ), 32'h0);
      bus_read(O_VEC, 32'h0, "s0_vec_idle");

      // Mask width and address miss
      bus_write(O_MASK, 32'hFFFF_FFFF);
      bus_read(O_MASK, 32'h3F, "mask_trunc");
      raw_read({28'h00007F4, O_MASK, 2'b00}, 32'h0, "miss_read");

      // Two simultaneous edges: lowest index first
      irq_src = 6'h14;
      tick();
      irq_src = '0;
      tick();
      check("two_irq_a", 32'(IRQ), 32'h1);
      bus_read(O_VEC, 32'h8000_0002, "two_claim_a");
      bus_write(O_EOI, 32'h0);
      tick();
      check("two_irq_b", 32'(IRQ), 32'h1);
      bus_read(O_VEC, 32'h8000_0004, "two_claim_b");
      bus_write(O_EOI, 32'h0);
      bus_read(O_PEND, 32'h0, "two_pend_end");

      // Masked edge stays pending; unmasking raises IRQ two cycles later
      bus_write(O_MASK, 32'h00);
      irq_src = 6'h08;
      tick();
      irq_src = '0;
      bus_read(O_PEND, 32'h08, "msk_pend");
      tick();
      check("msk_irq_low", 32'(IRQ), 32'h0);
      bus_read(O_VEC, 32'h0, "msk_vec");
      bus_write(O_MASK, 32'h08);
      check("msk_irq_w1", 32'(IRQ), 32'h0);
      tick();
      check("msk_irq_w2", 32'(IRQ), 32'h1);
      bus_read(O_VEC, 32'h8000_0003, "msk_claim");
      bus_write(O_EOI, 32'h0);
      bus_read(O_PEND, 32'h0, "msk_pend_end");

      // W1C before the claim withdraws the request
      bus_write(O_MASK, 32'h02);
      irq_src = 6'h02;
      tick();
      irq_src = '0;
      tick();
      check("w1c_irq_hi", 32'(IRQ), 32'h1);
      bus_write(O_PEND, 32'h02);
      tick();
      check("w1c_irq_lo", 32'(IRQ), 32'h0);
      bus_read(O_VEC,  32'h0, "w1c_vec");
      bus_read(O_PEND, 32'h0, "w1c_pend");

      // Reset mid-service, then a line held high across release
      bus_write(O_MASK, 32'h01);
      irq_src = 6'h01;
      tick();
      irq_src = '0;
      tick();
      check("svc_irq_hi", 32'(IRQ), 32'h1);
      bus_read(O_VEC, 32'h8000_0000, "svc_claim");
      irq_src = 6'h01;
      reset   = 1'b0;
      #1;
      check("mid_rst_irq", 32'(IRQ), 32'h0);
      bus_read(O_MASK, 32'h0, "mid_rst_mask");
      bus_read(O_PEND, 32'h0, "mid_rst_pend");
      bus_read(O_VEC,  32'h0, "mid_rst_vec");
      bus_read(O_EOI,  32'h0, "mid_rst_eoi");
      reset = 1'b1;
      repeat (3) tick();
      bus_read(O_PEND, 32'h0, "held_no_pend");
      check("held_irq", 32'(IRQ), 32'h0);
      irq_src = '0;
      tick();
      irq_src = 6'h01;
      tick();
      irq_src = '0;
      bus_read(O_PEND, 32'h1, "fresh_pend");
      tick();
      check("fresh_irq_masked", 32'(IRQ), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
